// File: rtl/eth_tx_frame_sched_pkg.sv
// Shared types and constants for the Ethernet TX frame scheduler.
// Holds the FSM state set, address/length width, requester count and header/meta bundles.
package eth_tx_frame_sched_pkg;

  localparam int AW   = 11;
  localparam int NREQ = 2;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PRIME,
    ST_DATA,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } hdr_t;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
  } meta_t;

endpackage

// File: rtl/eth_tx_frame_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, favours the loser of the last grant.
// Zero latency; pointer moves only when advance is high with a grant, requester 0 favoured after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (prio) begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end else begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/eth_tx_frame_sched.sv
// Arbitrates two frame requesters and emits header + payload stream from shared RAM; done at len+3 after grant.
// Header waits on hdr_ready, payload stalls cleanly on tready; len==0 completes immediately with req_err.
module eth_tx_frame_sched
  import eth_tx_frame_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [48*NREQ-1:0]   req_dest_mac,
  input  logic [48*NREQ-1:0]   req_src_mac,
  input  logic [16*NREQ-1:0]   req_type,
  input  logic [AW*NREQ-1:0]   req_base,
  input  logic [AW*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]      req_done,
  output logic                 req_err,
  output logic [AW-1:0]        pay_raddr,
  input  logic [7:0]           pay_rdata,
  input  logic                 busy,
  output logic                 s_eth_hdr_valid,
  input  logic                 s_eth_hdr_ready,
  output logic [47:0]          s_eth_dest_mac,
  output logic [47:0]          s_eth_src_mac,
  output logic [15:0]          s_eth_type,
  output logic [7:0]           s_eth_payload_axis_tdata,
  output logic                 s_eth_payload_axis_tvalid,
  output logic                 s_eth_payload_axis_tlast,
  output logic                 s_eth_payload_axis_tuser,
  input  logic                 s_eth_payload_axis_tready
);

  state_t          state, state_nxt;
  hdr_t            hdr_q, hdr_sel;
  meta_t           meta_q, meta_sel;
  logic [NREQ-1:0] arb_req, arb_grant, grant_q;
  logic            start, beat_acc, last_beat, err_q;
  logic [AW-1:0]   addr_q, cnt_q;
  logic [7:0]      tdata_q;

  assign start     = (state == ST_IDLE) && !busy && (req_valid != '0);
  assign arb_req   = start ? req_valid : '0;
  assign beat_acc  = (state == ST_DATA) && s_eth_payload_axis_tready;
  assign last_beat = (cnt_q == (meta_q.len - ADDR_ONE));

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (start),
    .grant   (arb_grant)
  );

  always_comb begin
    hdr_sel  = '0;
    meta_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        hdr_sel.dest_mac = req_dest_mac[48*i +: 48];
        hdr_sel.src_mac  = req_src_mac[48*i +: 48];
        hdr_sel.eth_type = req_type[16*i +: 16];
        meta_sel.base    = req_base[AW*i +: AW];
        meta_sel.len     = req_len[AW*i +: AW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt                 = state;
    s_eth_hdr_valid           = 1'b0;
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    req_done                  = '0;
    req_err                   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (meta_sel.len == '0) ? ST_DONE : ST_HDR;
      end
      ST_HDR: begin
        s_eth_hdr_valid = 1'b1;
        if (s_eth_hdr_ready) state_nxt = ST_PRIME;
      end
      ST_PRIME: state_nxt = ST_DATA;
      ST_DATA: begin
        s_eth_payload_axis_tvalid = 1'b1;
        s_eth_payload_axis_tlast  = last_beat;
        if (s_eth_payload_axis_tready && last_beat) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        req_done  = grant_q;
        req_err   = err_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // addr_q is the address whose byte sits in pay_rdata next; an accepted beat fetches one further.
  assign pay_raddr                = addr_q + {{(AW-1){1'b0}}, beat_acc};
  assign s_eth_payload_axis_tdata = tdata_q;
  assign s_eth_payload_axis_tuser = 1'b0;
  assign s_eth_dest_mac           = hdr_q.dest_mac;
  assign s_eth_src_mac            = hdr_q.src_mac;
  assign s_eth_type               = hdr_q.eth_type;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q   <= '0;
      meta_q  <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            hdr_q   <= hdr_sel;
            meta_q  <= meta_sel;
            grant_q <= arb_grant;
            err_q   <= (meta_sel.len == '0);
            addr_q  <= meta_sel.base;
            cnt_q   <= '0;
          end
        end
        ST_HDR: begin
          if (s_eth_hdr_ready) addr_q <= addr_q + ADDR_ONE;
        end
        ST_PRIME: tdata_q <= pay_rdata;
        ST_DATA: begin
          if (s_eth_payload_axis_tready) begin
            tdata_q <= pay_rdata;
            addr_q  <= addr_q + ADDR_ONE;
            cnt_q   <= cnt_q + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Directed bench for eth_tx_frame_sched: frame vector table plus busy, wrap and mid-frame reset sequences.
module tb_eth_tx_frame_sched;

  localparam logic [47:0] DEST0 = 48'h02AA_0000_0001;
  localparam logic [47:0] DEST1 = 48'h02AA_0000_0002;
  localparam logic [47:0] SRC0  = 48'h02BB_0000_0001;
  localparam logic [47:0] SRC1  = 48'h02BB_0000_0002;
  localparam logic [15:0] TYPE0 = 16'h0800;
  localparam logic [15:0] TYPE1 = 16'h86DD;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [95:0] req_dest_mac, req_src_mac;
  logic [31:0] req_type;
  logic [21:0] req_base, req_len;
  logic [1:0]  req_done;
  logic        req_err;
  logic [10:0] pay_raddr;
  logic [7:0]  pay_rdata;
  logic        busy;
  logic        s_eth_hdr_valid, s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac, s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, tready;

  always #5 clk = ~clk;

  eth_tx_frame_sched dut (
    .clk                       (clk),
    .rst                       (rst),
    .req_valid                 (req_valid),
    .req_dest_mac              (req_dest_mac),
    .req_src_mac               (req_src_mac),
    .req_type                  (req_type),
    .req_base                  (req_base),
    .req_len                   (req_len),
    .req_done                  (req_done),
    .req_err                   (req_err),
    .pay_raddr                 (pay_raddr),
    .pay_rdata                 (pay_rdata),
    .busy                      (busy),
    .s_eth_hdr_valid           (s_eth_hdr_valid),
    .s_eth_hdr_ready           (s_eth_hdr_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_eth_payload_axis_tdata  (tdata),
    .s_eth_payload_axis_tvalid (tvalid),
    .s_eth_payload_axis_tlast  (tlast),
    .s_eth_payload_axis_tuser  (tuser),
    .s_eth_payload_axis_tready (tready)
  );

  logic [7:0] mem [0:2047];
  always @(posedge clk) pay_rdata <= mem[pay_raddr];

  typedef struct {
    logic [1:0]  vld;
    logic [10:0] base0, len0, base1, len1;
    logic [15:0] rdy;
    logic        drop;
    logic [1:0]  exp_done;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t       vt [10];
  logic [10:0] raddr_log [0:63];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " ctl"}, 128'({s_eth_hdr_valid, tvalid, tlast, tuser, req_done, req_err}), 128'(0));
    chk({nm, " raddr"}, 128'(pay_raddr), 128'(0));
    chk({nm, " tdata"}, 128'(tdata), 128'(0));
    chk({nm, " hdr"}, 128'({s_eth_dest_mac, s_eth_src_mac, s_eth_type}), 128'(0));
  endtask

  // Caller is positioned 1ns after a rising edge with the DUT idle; returns likewise.
  task automatic run_one(input vec_t v, input string nm);
    int gi, done_cyc, hdr_cnt, hdr_first, first_beat, tl_cnt, tl_idx, bad;
    logic [10:0] eb, el, a;
    logic [7:0] beats [$];
    logic [111:0] hdr_seen, hdr_exp;
    logic [1:0] dn;
    logic er, prev_stall, prev_l;
    logic [7:0] prev_d;
    done_cyc = -1; hdr_cnt = 0; hdr_first = -1; first_beat = -1;
    tl_cnt = 0; tl_idx = -1; bad = 0; dn = 2'b00; er = 1'b0;
    prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0; hdr_seen = '0;
    req_base  = {v.base1, v.base0};
    req_len   = {v.len1, v.len0};
    req_valid = v.vld;
    for (int c = 0; c < 40; c++) begin
      tready = (c < 16) ? v.rdy[c] : 1'b1;
      if (v.drop && c == 1) req_valid = 2'b00;
      @(negedge clk);
      raddr_log[c] = pay_raddr;
      if (s_eth_hdr_valid) begin
        if (hdr_cnt == 0) begin
          hdr_first = c;
          hdr_seen  = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
        end
        hdr_cnt++;
      end
      if (tuser !== 1'b0) bad++;
      if (prev_stall && (tdata !== prev_d || tlast !== prev_l)) bad++;
      if (tvalid && tready) begin
        beats.push_back(tdata);
        if (first_beat < 0) first_beat = c;
        if (tlast) begin
          tl_cnt++;
          tl_idx = beats.size() - 1;
        end
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      if (req_done != 2'b00) begin
        dn = req_done;
        er = req_err;
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = req_valid & ~dn;
    tready = 1'b1;
    gi = v.exp_done[1] ? 1 : 0;
    eb = gi ? v.base1 : v.base0;
    el = gi ? v.len1 : v.len0;
    hdr_exp = (el == 11'd0) ? '0 : (gi ? {DEST1, SRC1, TYPE1} : {DEST0, SRC0, TYPE0});
    chk({nm, " done"}, 128'(dn), 128'(v.exp_done));
    chk({nm, " err"}, 128'(er), 128'(v.exp_err));
    chk({nm, " done_cyc"}, 128'(done_cyc), 128'(v.exp_cyc));
    chk({nm, " hdr_cnt"}, 128'(hdr_cnt), 128'((el != 11'd0) ? 1 : 0));
    chk({nm, " hdr_cyc"}, 128'(hdr_first), 128'((el != 11'd0) ? 1 : -1));
    chk({nm, " hdr"}, 128'(hdr_seen), 128'(hdr_exp));
    chk({nm, " first_beat"}, 128'(first_beat), 128'((el != 11'd0) ? 3 : -1));
    chk({nm, " nbeats"}, 128'(beats.size()), 128'(int'(el)));
    chk({nm, " tlast_cnt"}, 128'(tl_cnt), 128'((el != 11'd0) ? 1 : 0));
    chk({nm, " tlast_idx"}, 128'(tl_idx), 128'(int'(el) - 1));
    chk({nm, " hold_tuser"}, 128'(bad), 128'(0));
    for (int k = 0; k < int'(el); k++) begin
      a = eb + 11'(k);
      chk($sformatf("%s beat%0d", nm, k),
          128'((k < beats.size()) ? {1'b0, beats[k]} : 9'h100), 128'({1'b0, mem[a]}));
    end
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
    mem[11'h010] = 8'hAA; mem[11'h011] = 8'hBB; mem[11'h012] = 8'hCC; mem[11'h013] = 8'hDD;

    //            vld    base0    len0   base1    len1   rdy       drop  done   err  cyc
    vt[0] = '{2'b11, 11'h020, 11'd2, 11'h030, 11'd2, 16'hFFFF, 1'b0, 2'b01, 1'b0, 5};
    vt[1] = '{2'b10, 11'h020, 11'd2, 11'h030, 11'd2, 16'hFFFF, 1'b0, 2'b10, 1'b0, 5};
    vt[2] = '{2'b01, 11'h010, 11'd4, 11'h030, 11'd2, 16'hFFFF, 1'b0, 2'b01, 1'b0, 7};
    vt[3] = '{2'b11, 11'h040, 11'd2, 11'h048, 11'd3, 16'hFFFF, 1'b0, 2'b10, 1'b0, 6};
    vt[4] = '{2'b01, 11'h040, 11'd2, 11'h048, 11'd3, 16'hFFFF, 1'b0, 2'b01, 1'b0, 5};
    vt[5] = '{2'b01, 11'h0A0, 11'd0, 11'h048, 11'd3, 16'hFFFF, 1'b0, 2'b01, 1'b1, 1};
    vt[6] = '{2'b10, 11'h0A0, 11'd1, 11'h050, 11'd3, 16'hFF4F, 1'b0, 2'b10, 1'b0, 9};
    vt[7] = '{2'b01, 11'h060, 11'd1, 11'h050, 11'd3, 16'hFFFF, 1'b0, 2'b01, 1'b0, 4};
    vt[8] = '{2'b01, 11'h070, 11'd2, 11'h050, 11'd3, 16'hFFFF, 1'b1, 2'b01, 1'b0, 5};
    vt[9] = '{2'b01, 11'h7FE, 11'd4, 11'h050, 11'd3, 16'hFFFF, 1'b0, 2'b01, 1'b0, 7};

    rst = 1'b1; req_valid = 2'b00; busy = 1'b0; s_eth_hdr_ready = 1'b1; tready = 1'b1;
    req_dest_mac = {DEST1, DEST0}; req_src_mac = {SRC1, SRC0}; req_type = {TYPE1, TYPE0};
    req_base = '0; req_len = '0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("idle");
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_one(vt[i], $sformatf("v%0d", i));

    chk("wrap raddr0", 128'(raddr_log[1]), 128'(11'h7FE));
    chk("wrap raddr1", 128'(raddr_log[2]), 128'(11'h7FF));
    chk("wrap raddr2", 128'(raddr_log[3]), 128'(11'h000));
    chk("wrap raddr3", 128'(raddr_log[4]), 128'(11'h001));

    req_base = {11'h030, 11'h0C0}; req_len = {11'd2, 11'd3};
    busy = 1'b1; req_valid = 2'b01;
    repeat (3) begin
      @(negedge clk);
      chk("busy hold", 128'({s_eth_hdr_valid, tvalid, req_done}), 128'(0));
    end
    @(posedge clk); #1;
    busy = 1'b0;
    run_one('{2'b01, 11'h0C0, 11'd3, 11'h030, 11'd2, 16'hFFFF, 1'b0, 2'b01, 1'b0, 6}, "busy_rel");

    req_base = {11'h030, 11'h100}; req_len = {11'd2, 11'd5};
    req_valid = 2'b01; tready = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("rst_pre tvalid", 128'(tvalid), 128'(1));
    chk("rst_pre tdata", 128'(tdata), 128'(mem[11'h102]));
    rst = 1'b0;
    #1 check_zero("rst_async");
    req_valid = 2'b00;
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_done != 2'b00) done_seen++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (req_done != 2'b00) done_seen++;
    end
    chk("rst no_done", 128'(done_seen), 128'(0));
    @(posedge clk); #1;
    run_one('{2'b11, 11'h110, 11'd2, 11'h120, 11'd2, 16'hFFFF, 1'b0, 2'b01, 1'b0, 5}, "post_rst0");
    run_one('{2'b10, 11'h110, 11'd2, 11'h120, 11'd2, 16'hFFFF, 1'b0, 2'b10, 1'b0, 5}, "post_rst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
